// File: rtl/logic_pkg.sv
// ============================================================================
// Module  : logic_pkg
// Brief   : Op encoding and default width shared by bitwise_logic_pipe and its
//           benches.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_pkg;

  localparam int unsigned LOGIC_WIDTH_DEFAULT = 32;
  localparam int unsigned LOGIC_OP_BITS       = 3;

  typedef enum logic [LOGIC_OP_BITS-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_ACC_OR  = 3'd6,
    OP_ACC_CLR = 3'd7
  } logic_op_e;

  // Ops 6 and 7 read and write the accumulator instead of using operand b.
  function automatic logic is_acc_op(input logic_op_e op);
    return (op == OP_ACC_OR) || (op == OP_ACC_CLR);
  endfunction

endpackage : logic_pkg

`default_nettype wire

// File: rtl/bitwise_op.sv
// ============================================================================
// Module  : bitwise_op
// Brief   : Combinational per-bit logic function of a and b (ops 0-5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bitwise_op
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = LOGIC_WIDTH_DEFAULT
) (
  input  logic [LOGIC_OP_BITS-1:0] op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         y
);

  logic_op_e w_op;

  assign w_op = logic_op_e'(op);

  always_comb begin
    y = '0;
    case (w_op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule : bitwise_op

`default_nettype wire

// File: rtl/bitwise_logic_pipe.sv
// ============================================================================
// Module  : bitwise_logic_pipe
// Brief   : One-stage valid/ready bitwise ALU with an OR-accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bitwise_logic_pipe
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = LOGIC_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LOGIC_OP_BITS-1:0] op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     zero
);

  logic_op_e        w_op;
  logic             w_accept;
  logic [WIDTH-1:0] w_logic_y;
  logic [WIDTH-1:0] w_alu;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic [WIDTH-1:0] acc_q,       acc_d;

  assign w_op = logic_op_e'(op);

  // Reset gates in_ready so a beat offered during reset is never consumed.
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  bitwise_op #(
    .WIDTH (WIDTH)
  ) u_bitwise_op (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (w_logic_y)
  );

  always_comb begin
    w_alu = w_logic_y;
    case (w_op)
      OP_ACC_OR:  w_alu = acc_q | a;
      OP_ACC_CLR: w_alu = acc_q;
      default:    w_alu = w_logic_y;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      result_d    = w_alu;
      zero_d      = (w_alu == '0);
      if (is_acc_op(w_op)) begin
        acc_d = (w_op == OP_ACC_OR) ? w_alu : '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule : bitwise_logic_pipe

`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
// ============================================================================
// Module  : tb_bitwise_logic_pipe
// Brief   : Directed and random checks of bitwise_logic_pipe against a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitwise_logic_pipe;
  import logic_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the consumer should see, plus the accumulator.
  logic         m_ov  = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_z   = 1'b0;
  logic [W-1:0] m_acc = '0;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] acc);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return acc | x;
      default: return acc;
    endcase
  endfunction

  // One clock cycle: drive, check in_ready, advance the model, check outputs.
  task automatic step(input logic r, input logic iv, input logic [2:0] o,
                      input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ordy);
    logic         exp_rdy;
    logic [W-1:0] v;
    @(negedge clk);
    reset     = r;
    in_valid  = iv;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    #1;
    exp_rdy = !r && (!m_ov || ordy);
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (r) begin
      m_ov = 1'b0; m_res = '0; m_z = 1'b0; m_acc = '0;
    end else if (iv && exp_rdy) begin
      v     = ref_fn(o, aa, bb, m_acc);
      m_ov  = 1'b1;
      m_res = v;
      m_z   = (v == '0);
      if (o == 3'd6) m_acc = v;
      else if (o == 3'd7) m_acc = '0;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("result", result, m_res);
    chk("zero", zero, m_z);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;

    // Reset held two cycles
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
    step(1'b1, 1'b1, 3'd1, 32'h1, 32'h1, 1'b1);
    chk("rst_result", result, 64'h0);
    chk("rst_zero", zero, 64'h0);

    // OR, then NOR/XNOR of all-ones
    step(1'b0, 1'b1, 3'd1, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b1);
    chk("or_result", result, 64'hFFFF_00FF);
    chk("or_zero", zero, 64'h0);
    step(1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("nor_result", result, 64'h0);
    chk("nor_zero", zero, 64'h1);
    step(1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("xnor_result", result, 64'hFFFF_FFFF);
    chk("xnor_zero", zero, 64'h0);

    // Backpressure: AND result held while a second beat waits
    step(1'b0, 1'b1, 3'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd1, 32'h1, 32'h2, 1'b0);
      chk("bp_ready", in_ready, 64'h0);
      chk("bp_hold", result, 64'h0000_1234);
    end
    step(1'b0, 1'b1, 3'd1, 32'h1, 32'h2, 1'b1);
    chk("bp_second", result, 64'h3);
    step(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);
    chk("bp_drain", out_valid, 64'h0);

    // Accumulator sequence
    step(1'b0, 1'b1, 3'd6, 32'h1, 32'hDEAD, 1'b1);
    chk("acc_1", result, 64'h1);
    step(1'b0, 1'b1, 3'd6, 32'h4, 32'hBEEF, 1'b1);
    chk("acc_5", result, 64'h5);
    step(1'b0, 1'b1, 3'd7, 32'h0, 32'h0, 1'b1);
    chk("acc_clr", result, 64'h5);
    step(1'b0, 1'b1, 3'd6, 32'h2, 32'h0, 1'b1);
    chk("acc_2", result, 64'h2);
    step(1'b0, 1'b1, 3'd6, 32'h0, 32'h0, 1'b1);
    chk("acc_end", result, 64'h2);

    // Reset mid-operation with acc=5 and a held result
    step(1'b0, 1'b1, 3'd7, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 3'd6, 32'h5, 32'h0, 1'b1);
    step(1'b1, 1'b1, 3'd6, 32'h8, 32'h0, 1'b0);
    chk("midrst_valid", out_valid, 64'h0);
    step(1'b0, 1'b1, 3'd6, 32'h0, 32'h0, 1'b1);
    chk("midrst_result", result, 64'h0);
    chk("midrst_zero", zero, 64'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rb = W'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           ra, rb, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bitwise_logic_pipe

`default_nettype wire
